uart_tx_conx: RTL and testbench

UART transmitter: serialises one byte per request onto `tx` as 8N1 (optionally 8E1) at the same 16x-oversampled bit timing the receive path uses. It has a single-word request/busy/done handshake, so a controller or FSM can stream bytes back to the host. It is the transmit counterpart of the receive connection block and sits beside it at the top level, sharing `clk`/`rst` and the baud divisor value.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tick_gen.sv | 36 +++
 rtl/uart_tx_conx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_conx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: the transmit FSM state type and the default baud constants.
// The receive side imports the same constants so both directions stay in step.
package uart_pkg;

    localparam int unsigned UART_CLK_DIV_DEFAULT    = 325;  // 50 MHz / (9600 * 16)
    localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider for the transmitter. Unlike the free-running receive baud
// generator it has a synchronous clear, so every frame starts on a fresh tick boundary.
module uart_tick_gen #(
    parameter int unsigned CLK_DIV = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    // Count 0..CLK_DIV-1, wrapping on the tick or when cleared.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_conx.sv
// UART transmitter: one byte per txStart, sent LSB first as 8N1 on a 16x oversampled
// bit clock. Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
// All outputs come straight from flops so tx never glitches.
module uart_tx_conx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = UART_CLK_DIV_DEFAULT,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] txData,
    output logic                 tx,
    output logic                 txBusy,
    output logic                 txDone
);

    localparam int unsigned OsW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IdxMax = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned IdxW   = (IdxMax > 1) ? $clog2(IdxMax) : 1;

    localparam logic [OsW-1:0]  OsLast   = OsW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [IdxW-1:0]       idx_q, idx_d;    // data bit index, reused as stop bit index
    logic [OsW-1:0]        os_q, os_d;      // ticks elapsed in the current bit
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic tick;
    logic bit_end;

    // Holding the divider clear while idle realigns it to the accept edge.
    uart_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == StIdle),
        .tick  (tick)
    );

    assign bit_end = tick && (os_q == OsLast);

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        os_d     = os_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if ((state_q != StIdle) && tick) begin
            os_d = bit_end ? '0 : os_q + OsW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (txStart) begin
                    shift_d  = txData;
                    idx_d    = '0;
                    os_d     = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^txData;
`endif
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DataLast) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    if (idx_q == StopLast) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            os_q     <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            os_q     <= os_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx     = tx_q;
    assign txBusy = busy_q;
    assign txDone = done_q;

endmodule

// File: tb/tb_uart_tx_conx.sv
// Scoreboard bench for uart_tx_conx: the stimulus pushes the expected frame for every
// accepted byte, and a monitor captures tx cycle by cycle and checks it on each txDone.
module tb_uart_tx_conx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int BitCyc    = 8;                       // CLK_DIV=2 * OVERSAMPLE=4
    localparam int FrameCyc  = (10 + P) * BitCyc;
    localparam int DefFrame  = (10 + P) * 325 * 16;

    typedef struct {
        logic [10:0] bits;   // bit 0 is the start bit
        int          nbits;
        int          acc;    // cycle in which txStart was accepted
    } exp_t;

    logic       clk;
    logic       rst;
    logic       txStart;
    logic [7:0] txData;
    logic       tx, txBusy, txDone;
    logic       def_start;
    logic [7:0] def_data;
    logic       def_tx, def_busy, def_done;

    int   cyc;
    int   checks;
    int   errors;
    int   done_count;
    exp_t sb[$];

    uart_tx_conx #(
        .CLK_DIV    (2),
        .OVERSAMPLE (4),
        .DATA_BITS  (8),
        .STOP_BITS  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .txStart (txStart),
        .txData  (txData),
        .tx      (tx),
        .txBusy  (txBusy),
        .txDone  (txDone)
    );

    uart_tx_conx u_def (
        .clk     (clk),
        .rst     (rst),
        .txStart (def_start),
        .txData  (def_data),
        .tx      (def_tx),
        .txBusy  (def_busy),
        .txDone  (def_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic par, input int acc);
        exp_t e;
        e.bits    = '1;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1 + i] = d[i];
        if (P == 1) e.bits[9] = par;
        e.nbits = 10 + P;
        e.acc   = acc;
        return e;
    endfunction

    // Monitor: capture tx while busy, compare against the scoreboard on txDone.
    logic [95:0] obs;
    logic [95:0] ew;
    int          n_obs;
    int          start_cyc;
    logic        busy_prev;
    exp_t        e;
    initial begin
        busy_prev = 1'b0;
        n_obs     = 0;
        obs       = '0;
        start_cyc = 0;
        forever begin
            @(negedge clk);
            if (txBusy === 1'b1) begin
                if (!busy_prev) begin
                    n_obs     = 0;
                    obs       = '0;
                    start_cyc = cyc;
                end
                if (n_obs < 96) obs[n_obs] = tx;
                n_obs++;
            end
            if (txDone === 1'b1) begin
                done_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: txDone at cycle %0d, expected none", cyc);
                end else begin
                    e  = sb.pop_front();
                    ew = '0;
                    for (int k = 0; k < e.nbits * BitCyc; k++) ew[k] = e.bits[k / BitCyc];
                    check("busy_start", start_cyc, e.acc + 1);
                    check("busy_len", n_obs, e.nbits * BitCyc);
                    check("tx_wave", obs, ew);
                    check("done_time", cyc, e.acc + 1 + e.nbits * BitCyc);
                    check("done_line", {tx, txBusy}, 2'b10);
                end
            end
            busy_prev = (txBusy === 1'b1);
        end
    end

    task automatic send(input logic [7:0] d, input logic par, input bit push, output int acc);
        @(posedge clk);
        #1;
        txData  = d;
        txStart = 1'b1;
        acc     = cyc;
        if (push) sb.push_back(mk(d, par, acc));
        @(posedge clk);
        #1;
        txStart = 1'b0;
        txData  = ~d;     // later data changes must not reach the line
        @(negedge clk);
        check("accept_latency", {tx, txBusy}, 2'b01);
    endtask

    task automatic wait_done(input int limit, input string name, output int at);
        int k;
        k  = 0;
        at = -1;
        do begin
            @(negedge clk);
            k++;
        end while (txDone !== 1'b1 && k < limit);
        checks++;
        if (txDone !== 1'b1) begin
            errors++;
            $display("FAIL %s: no txDone within %0d cycles, expected one", name, limit);
        end else begin
            at = cyc;
        end
    endtask

    initial begin
        int acc, d1, d2, dc0, busy_cnt, k;
        rst       = 1'b1;
        txStart   = 1'b0;
        txData    = 8'h00;
        def_start = 1'b0;
        def_data  = 8'h00;

        // Reset: outputs idle on every reset cycle, both instances.
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outs", {tx, txBusy, txDone}, 3'b100);
            check("reset_outs_default", {def_tx, def_busy, def_done}, 3'b100);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte A5: line 0,1,0,1,0,0,1,0,1,1; done 81 cycles after accept.
        send(8'hA5, 1'b0, 1'b1, acc);
        wait_done(200, "a5_done", d1);

        // Ignored request: FF pulse mid-frame leaves the A5 frame intact.
        send(8'hA5, 1'b0, 1'b1, acc);
        repeat (39) @(posedge clk);
        #1;
        txData  = 8'hFF;
        txStart = 1'b1;
        @(posedge clk);
        #1;
        txStart = 1'b0;
        wait_done(200, "ignored_done", d1);
        repeat (30) @(negedge clk);

        // Back-to-back: 00 requested mid-frame and held across txDone.
        send(8'h81, 1'b0, 1'b1, acc);
        repeat (59) @(posedge clk);
        #1;
        txData  = 8'h00;
        txStart = 1'b1;
        wait_done(200, "b2b_first_done", d1);
        sb.push_back(mk(8'h00, 1'b0, d1));
        @(posedge clk);
        #1;
        txStart = 1'b0;
        @(negedge clk);
        check("b2b_start", {tx, txBusy}, 2'b01);
        wait_done(200, "b2b_second_done", d2);
        // One frame plus the accepting done cycle: 80 cycles strictly between the pulses.
        check("b2b_spacing", d2 - d1, FrameCyc + 1);

        // Reset at cycle 30 of the 3C frame: abandoned, no txDone.
        send(8'h3C, 1'b0, 1'b0, acc);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        dc0 = done_count;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_outs", {tx, txBusy, txDone}, 3'b100);
        repeat (120) @(negedge clk);
        check("midreset_no_done", done_count, dc0);

        // Reset and request together: reset wins.
        @(posedge clk);
        #1;
        rst     = 1'b1;
        txStart = 1'b1;
        txData  = 8'h55;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        txStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_wins", {tx, txBusy}, 2'b10);
        end

        // Parity vectors: 07 has three ones (parity 1), 03 has two (parity 0).
        send(8'h07, 1'b1, 1'b1, acc);
        wait_done(200, "par07_done", d1);
        send(8'h03, 1'b0, 1'b1, acc);
        wait_done(200, "par03_done", d1);

        // Default parameters: frame length in busy cycles.
        @(posedge clk);
        #1;
        def_data  = 8'hA5;
        def_start = 1'b1;
        @(posedge clk);
        #1;
        def_start = 1'b0;
        busy_cnt  = 0;
        k         = 0;
        do begin
            @(negedge clk);
            k++;
            if (def_busy === 1'b1) busy_cnt++;
        end while (def_done !== 1'b1 && k < DefFrame + 1000);
        check("default_done_seen", def_done, 1'b1);
        check("default_frame_len", busy_cnt, DefFrame);

        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
